// File: rtl/int2float_sched.sv
// Round-robin scheduler sharing one external int2float converter among NREQ
// requesters: S1 registers the operand, S2 captures M/E with the source ID.
module int2float_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*11-1:0]   i_req_data,
    output logic [NREQ-1:0]      o_req_ready,
    output logic [10:0]          o_conv_b,
    input  logic [3:0]           i_conv_m,
    input  logic [2:0]           i_conv_e,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [3:0]           o_out_m,
    output logic [2:0]           o_out_e,
    output logic [IDW-1:0]       o_out_id,
    output logic                 o_busy,
    output logic [CNTW-1:0]      o_conv_count
);

    logic [10:0]     r_conv_b;
    logic [IDW-1:0]  r_s1_id;
    logic            r_s1_valid;
    logic [IDW-1:0]  r_rr;
    logic            r_out_valid;
    logic [3:0]      r_out_m;
    logic [2:0]      r_out_e;
    logic [IDW-1:0]  r_out_id;
    logic [CNTW-1:0] r_count;

    logic [10:0]     w_ops [NREQ];
    logic            w_grant_found;
    logic [IDW-1:0]  w_grant_idx;
    logic [IDW-1:0]  w_rr_next;
    logic            w_s2_free;
    logic            w_s1_adv;
    logic            w_s1_free;
    logic            w_accept;
    logic            w_pop;
    int              w_try;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_ops[i] = i_req_data[11*i +: 11];
        end
    end

    // NOTE: every variable gets a default before the search loop so the block
    // stays purely combinational even when no requester is valid.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_try         = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_try = int'(r_rr) + k;
            if (w_try >= NREQ) w_try = w_try - NREQ;
            if (!w_grant_found && i_req_valid[IDW'(w_try)]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = IDW'(w_try);
            end
        end
    end

    assign w_s2_free = !r_out_valid | i_out_ready;
    assign w_s1_adv  = r_s1_valid & w_s2_free;
    assign w_s1_free = !r_s1_valid | w_s1_adv;
    assign w_accept  = w_grant_found & w_s1_free & !i_reset;
    assign w_pop     = r_out_valid & i_out_ready;
    // Explicit wrap keeps rr inside 0..NREQ-1 when NREQ is not a power of 2.
    assign w_rr_next = (w_grant_idx == IDW'(NREQ-1)) ? '0 : w_grant_idx + 1'b1;

    assign o_req_ready = w_accept ? (NREQ'(1) << w_grant_idx) : '0;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_conv_b    <= '0;
            r_s1_id     <= '0;
            r_s1_valid  <= 1'b0;
            r_rr        <= '0;
            r_out_valid <= 1'b0;
            r_out_m     <= '0;
            r_out_e     <= '0;
            r_out_id    <= '0;
            r_count     <= '0;
        end else begin
            if (w_accept) begin
                r_conv_b   <= w_ops[w_grant_idx];
                r_s1_id    <= w_grant_idx;
                r_s1_valid <= 1'b1;
                r_rr       <= w_rr_next;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_adv) begin
                r_out_m     <= i_conv_m;
                r_out_e     <= i_conv_e;
                r_out_id    <= r_s1_id;
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end

            if (w_pop && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_conv_b     = r_conv_b;
    assign o_out_valid  = r_out_valid;
    assign o_out_m      = r_out_m;
    assign o_out_e      = r_out_e;
    assign o_out_id     = r_out_id;
    assign o_busy       = r_s1_valid | r_out_valid;
    assign o_conv_count = r_count;

endmodule

// File: tb/tb_int2float_sched.sv
// Randomized bench for int2float_sched: a queue/occupancy reference model predicts
// grants, latency and results; a separate monitor scores every delivered result.
module tb_int2float_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              i_reset;
    logic [NREQ-1:0]   i_req_valid;
    logic [NREQ*11-1:0] i_req_data;
    logic              i_out_ready;

    logic [NREQ-1:0]   o_req_ready,  o_req_ready4;
    logic [10:0]       o_conv_b,     o_conv_b4;
    logic [3:0]        conv_m,       conv_m4;
    logic [2:0]        conv_e,       conv_e4;
    logic              o_out_valid,  o_out_valid4;
    logic [3:0]        o_out_m,      o_out_m4;
    logic [2:0]        o_out_e,      o_out_e4;
    logic [IDW-1:0]    o_out_id,     o_out_id4;
    logic              o_busy,       o_busy4;
    logic [15:0]       o_conv_count;
    logic [3:0]        o_conv_count4;

    // Stand-in converter: arbitrary but depends on every operand bit.
    function automatic logic [3:0] conv_m_fn(input logic [10:0] b);
        return b[3:0] ^ b[7:4] ^ 4'hA;
    endfunction
    function automatic logic [2:0] conv_e_fn(input logic [10:0] b);
        return b[10:8] ^ 3'd6;
    endfunction

    assign conv_m  = conv_m_fn(o_conv_b);
    assign conv_e  = conv_e_fn(o_conv_b);
    assign conv_m4 = conv_m_fn(o_conv_b4);
    assign conv_e4 = conv_e_fn(o_conv_b4);

    int2float_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(16)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_req_valid(i_req_valid),
        .i_req_data(i_req_data), .o_req_ready(o_req_ready), .o_conv_b(o_conv_b),
        .i_conv_m(conv_m), .i_conv_e(conv_e), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready), .o_out_m(o_out_m), .o_out_e(o_out_e),
        .o_out_id(o_out_id), .o_busy(o_busy), .o_conv_count(o_conv_count)
    );

    int2float_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(4)) dut4 (
        .i_clock(clk), .i_reset(i_reset), .i_req_valid(i_req_valid),
        .i_req_data(i_req_data), .o_req_ready(o_req_ready4), .o_conv_b(o_conv_b4),
        .i_conv_m(conv_m4), .i_conv_e(conv_e4), .o_out_valid(o_out_valid4),
        .i_out_ready(i_out_ready), .o_out_m(o_out_m4), .o_out_e(o_out_e4),
        .o_out_id(o_out_id4), .o_busy(o_busy4), .o_conv_count(o_conv_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]     m;
        logic [2:0]     e;
        logic [IDW-1:0] id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight items form an in-order queue of at most two;
    // a new item is accepted when fewer than two are held or the oldest leaves now.
    int          m_rr, m_n, m_cnt, m_cnt4, m_g;
    bit          m_last, m_found, m_acc, m_pop, m_ov;
    logic [10:0] m_convb, m_d;

    always @(negedge clk) begin
        if (i_reset) begin
            check("req_ready_in_reset", o_req_ready, 0);
            m_rr = 0; m_n = 0; m_cnt = 0; m_cnt4 = 0; m_last = 0; m_convb = '0;
            sb.delete();
        end else begin
            m_ov = (m_n - int'(m_last)) > 0;
            check("out_valid", o_out_valid, m_ov);
            check("busy", o_busy, m_n > 0);
            check("conv_b", o_conv_b, m_convb);
            check("conv_count", o_conv_count, m_cnt);
            check("conv_count_sat4", o_conv_count4, m_cnt4);

            m_pop   = m_ov && i_out_ready;
            m_found = 0;
            m_g     = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!m_found && i_req_valid[(m_rr + k) % NREQ]) begin
                    m_found = 1;
                    m_g     = (m_rr + k) % NREQ;
                end
            end
            m_acc = m_found && (m_n < 2 || i_out_ready);
            check("req_ready", o_req_ready, m_acc ? (32'd1 << m_g) : 32'd0);

            if (m_acc) begin
                m_d = i_req_data[11*m_g +: 11];
                sb.push_back('{m: conv_m_fn(m_d), e: conv_e_fn(m_d), id: IDW'(m_g)});
                m_convb = m_d;
                m_rr    = (m_g + 1) % NREQ;
            end
            if (m_pop) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            m_n    = m_n + int'(m_acc) - int'(m_pop);
            m_last = m_acc;
        end
    end

    exp_t mon_exp;
    always @(negedge clk) begin
        if (!i_reset && o_out_valid === 1'b1 && i_out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underflow: got result id %0d expected none at %0t", o_out_id, $time);
            end else begin
                mon_exp = sb.pop_front();
                check("out_m", o_out_m, mon_exp.m);
                check("out_e", o_out_e, mon_exp.e);
                check("out_id", o_out_id, mon_exp.id);
            end
        end
    end

    task automatic drive(input logic [NREQ-1:0] v, input logic rdy);
        i_req_valid = v;
        i_out_ready = rdy;
        for (int i = 0; i < NREQ; i++) i_req_data[11*i +: 11] = 11'($urandom);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        i_reset = 1'b1;
        drive('0, 1'b1);
        tick(2);
        i_reset = 1'b0;
        tick(1);

        // Single request from requester 1
        drive(4'b0010, 1'b1);
        i_req_data[21:11] = 11'h0A5;
        tick(1);
        drive('0, 1'b1);
        tick(4);

        // Fairness: all requesters valid, sink always ready
        for (int c = 0; c < 12; c++) begin drive('1, 1'b1); tick(1); end

        // Backpressure then release
        for (int c = 0; c < 5; c++) begin drive('1, 1'b0); tick(1); end
        for (int c = 0; c < 8; c++) begin drive('1, 1'b1); tick(1); end

        // Idle requesters are skipped
        drive('0, 1'b1);
        tick(3);
        for (int c = 0; c < 6; c++) begin drive(4'b1001, 1'b1); tick(1); end

        // Random traffic
        for (int c = 0; c < 300; c++) begin
            drive(NREQ'($urandom), ($urandom_range(0, 3) != 0));
            tick(1);
        end

        // Reset with both stages full
        for (int c = 0; c < 3; c++) begin drive('1, 1'b0); tick(1); end
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;

        // Enough deliveries to saturate the 4-bit counter
        for (int c = 0; c < 30; c++) begin drive('1, 1'b1); tick(1); end

        drive('0, 1'b1);
        tick(4);
        check("scoreboard_drained", sb.size(), 0);
        check("count4_final", o_conv_count4, 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
